// File: rtl/io_port_pkg.sv
// Shared defaults and sizing helpers for the processor I/O port bridge.
// The optional overflow counter is enabled by defining IO_PORT_OVF_CNT_EN.
package io_port_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 4;

  // Pointer width for a power-of-two FIFO; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/io_port_fifo.sv
// First-word fall-through FIFO used on the OUT side of the I/O port bridge.
module io_port_fifo
  import io_port_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/io_port_bridge.sv
// Bridges processor IN/OUT instructions to valid/ready streams.
// Define IO_PORT_OVF_CNT_EN to add a saturating ovf_count output.
module io_port_bridge
  import io_port_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              out_strobe,
  input  logic [DATA_W-1:0] out_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              in_strobe,
  output logic [DATA_W-1:0] in_data,
  output logic              in_underflow,
  output logic              out_overflow
`ifdef IO_PORT_OVF_CNT_EN
  ,
  output logic [7:0]        ovf_count
`endif
);

  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              push;
  logic              drop;
  logic [DATA_W-1:0] hold;
  logic              hold_valid;

  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign pop  = m_valid & m_ready;
  assign push = out_strobe & (~fifo_full | pop);
  assign drop = out_strobe & fifo_full & ~pop;

  io_port_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (out_data),
    .rdata (m_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_valid = ~fifo_empty;

  assign s_ready = ~hold_valid | in_strobe;
  assign in_data = hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold         <= '0;
      hold_valid   <= 1'b0;
      in_underflow <= 1'b0;
    end else begin
      in_underflow <= in_strobe & ~hold_valid;
      if (s_valid && s_ready) begin
        hold       <= s_data;
        hold_valid <= 1'b1;
      end else if (in_strobe) begin
        hold_valid <= 1'b0;
      end
    end
  end

`ifdef IO_PORT_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      out_overflow <= 1'b0;
      ovf_count    <= 8'd0;
    end else begin
      out_overflow <= drop;
      if (drop && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) out_overflow <= 1'b0;
    else       out_overflow <= drop;
  end
`endif

endmodule

// File: doc/io_port_bridge.md
IO_PORT_BRIDGE -- requirements
Module: io_port_bridge

Interface
REQ-001 Parameter DEPTH, default 4, number of OUT-side FIFO entries (power of two, 2..16).
REQ-002 Parameter DATA_W, default 16, port data width; matches processor inputPort/outputPort.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  reset is synchronous and active-high.
REQ-005 Port out_strobe  input  1  processor write-back stage executing OUT this cycle.
REQ-006 Port out_data  input  DATA_W  processor outputPort value; sampled when out_strobe=1.
REQ-007 Port m_valid  output  1  FIFO head valid toward the external consumer.
REQ-008 Port m_data  output  DATA_W  FIFO head data (first-word fall-through).
REQ-009 Port m_ready  input  1  consumer accepts the head this cycle.
REQ-010 Port s_valid  input  1  external producer offers an input word.
REQ-011 Port s_data  input  DATA_W  external input word.
REQ-012 Port s_ready  output  1  bridge accepts s_data this cycle.
REQ-013 Port in_strobe  input  1  processor decode stage executing IN this cycle.
REQ-014 Port in_data  output  DATA_W  value driven onto processor inputPort.
REQ-015 Port in_underflow  output  1  one-cycle pulse: IN consumed with no valid input word.
REQ-016 Port out_overflow  output  1  one-cycle pulse: OUT write dropped because FIFO full.

Function
REQ-017 OUT push: out_strobe=1 and (count<DEPTH or pop this cycle) SHALL write out_data at the tail; visible on m_data/m_valid the next cycle.
REQ-018 OUT pop: m_valid=1 and m_ready=1 SHALL advance the head; m_ready while m_valid=0 SHALL have no effect.
REQ-019 Full with simultaneous push and pop SHALL accept both; count stays DEPTH.
REQ-020 Empty with out_strobe SHALL NOT bypass: m_valid rises one cycle after the strobe.
REQ-021 Full without pop plus out_strobe SHALL drop the word, leave FIFO unchanged, and pulse out_overflow the next cycle.
REQ-022 m_valid SHALL equal (count!=0); pointers SHALL wrap modulo DEPTH; count width SHALL be clog2(DEPTH)+1.
REQ-023 IN holding register: s_ready SHALL equal (!hold_valid or in_strobe); s_valid and s_ready SHALL load s_data into hold and set hold_valid.
REQ-024 in_data SHALL combinationally equal the hold register; in_strobe with hold_valid=1 SHALL clear hold_valid unless reloaded the same cycle.
REQ-025 in_strobe with hold_valid=0 SHALL return the last held value and pulse in_underflow the next cycle.
REQ-026 IN and OUT sides SHALL operate independently; simultaneous activity on both SHALL have no interaction.

Reset
REQ-027 While reset=1: pointers, count, hold_valid, in_underflow, out_overflow SHALL be 0; hold register SHALL be 0; m_valid=0; s_ready=1.
REQ-028 Reset asserted mid-transfer SHALL discard all FIFO contents and any held input word; strobes during reset SHALL be ignored.

Configuration
REQ-029 Macro IO_PORT_OVF_CNT_EN defined: add output ovf_count [7:0], saturating at 255, incremented per dropped OUT write, cleared by reset.
REQ-030 Macro undefined: no ovf_count port or counter; out_overflow pulse behaviour unchanged.

Structure
REQ-031 Package io_port_pkg SHALL hold DATA_W default, DEPTH default, and the pointer-width function.
REQ-032 FIFO storage and pointers SHALL be the sub-module io_port_fifo (push/pop/full/empty); the IN holding register and pulse logic stay in the top level.

Verification
REQ-033 Reset, then out_strobe with 0x1234, 0x5678, m_ready=1 -> m_data 0x1234 then 0x5678 on consecutive cycles, m_valid then 0.
REQ-034 m_ready=0, five OUT strobes 0x0001..0x0005, DEPTH=4 -> FIFO holds 0x0001..0x0004, one out_overflow pulse, ovf_count=1 with IO_PORT_OVF_CNT_EN.
REQ-035 FIFO full, out_strobe 0x00AA with m_ready=1 -> no overflow; after drain the last word is 0x00AA.
REQ-036 s_valid with 0xBEEF, then in_strobe -> in_data=0xBEEF, s_ready=1 the same cycle; a second in_strobe -> in_data=0xBEEF, in_underflow pulse.
REQ-037 Reset asserted with three FIFO entries and hold_valid=1 -> next cycle m_valid=0, s_ready=1, in_data=0x0000.
